// File: rtl/seg_text_writer_pkg.sv
// Shared definitions for the segment text writer: commands, character codes, FSM states.
package seg_pkg;

  typedef enum logic [1:0] {
    CMD_PUT  = 2'b00,
    CMD_BKSP = 2'b01,
    CMD_CLR  = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    RENDER = 2'd2
  } state_e;

  localparam logic [5:0] CH_DASH       = 6'd36;
  localparam logic [5:0] CH_UNDERSCORE = 6'd37;
  localparam logic [7:0] SEG_BLANK     = 8'h00;

endpackage

// File: rtl/seg_text_writer_if.sv
// Command/character handshake between the symbol decoder and the text writer.
interface seg_text_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_cmd;
  logic [5:0] in_char;

  modport master (output in_valid, output in_cmd, output in_char, input in_ready);
  modport slave  (input in_valid, input in_cmd, input in_char, output in_ready);
endinterface

// File: rtl/seg_text_writer_char_enc.sv
// Character code to 7-segment byte {a,b,c,d,e,f,g,dp}; dp is always 0 here.
module seg_char_enc
  import seg_pkg::*;
(
  input  logic [5:0] i_code,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      6'd0:  o_seg = 8'hFC;
      6'd1:  o_seg = 8'h60;
      6'd2:  o_seg = 8'hDA;
      6'd3:  o_seg = 8'hF2;
      6'd4:  o_seg = 8'h66;
      6'd5:  o_seg = 8'hB6;
      6'd6:  o_seg = 8'hBE;
      6'd7:  o_seg = 8'hE0;
      6'd8:  o_seg = 8'hFE;
      6'd9:  o_seg = 8'hF6;
      6'd10: o_seg = 8'hEE; // A
      6'd11: o_seg = 8'h3E; // b
      6'd12: o_seg = 8'h9C; // C
      6'd13: o_seg = 8'h7A; // d
      6'd14: o_seg = 8'h9E; // E
      6'd15: o_seg = 8'h8E; // F
      6'd16: o_seg = 8'hBC; // G
      6'd17: o_seg = 8'h6E; // H
      6'd18: o_seg = 8'h0C; // I
      6'd19: o_seg = 8'h78; // J
      6'd20: o_seg = 8'hAE; // K
      6'd21: o_seg = 8'h1C; // L
      6'd22: o_seg = 8'hA8; // M
      6'd23: o_seg = 8'h2A; // n
      6'd24: o_seg = 8'h3A; // o
      6'd25: o_seg = 8'hCE; // P
      6'd26: o_seg = 8'hE6; // q
      6'd27: o_seg = 8'h0A; // r
      6'd28: o_seg = 8'hB6; // S
      6'd29: o_seg = 8'h1E; // t
      6'd30: o_seg = 8'h7C; // U
      6'd31: o_seg = 8'h38; // v
      6'd32: o_seg = 8'h54; // W
      6'd33: o_seg = 8'h92; // X
      6'd34: o_seg = 8'h76; // y
      6'd35: o_seg = 8'hDA; // Z
      CH_DASH:       o_seg = 8'h02;
      CH_UNDERSCORE: o_seg = 8'h10;
      default:       o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_text_writer.sv
// Character buffer + renderer feeding the 8-digit display scanner.
// Optional cursor blink on the rightmost dp: define SEG_TEXT_WRITER_CURSOR_BLINK_EN.
module seg_text_writer
  import seg_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BLINK_DIV = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  seg_text_writer_if.slave             s_in,
  output logic [63:0]                  seg_data,
  output logic [$clog2(DEPTH+1)-1:0]   char_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 8 || DEPTH > 64 || BLINK_DIV < 1) begin : g_bad_param
    $error("seg_text_writer: DEPTH must be 8..64 and BLINK_DIV >= 1");
  end

  state_e          r_state, w_state_nxt;
  cmd_e            r_cmd;
  logic [5:0]      r_char;
  logic [5:0]      r_buf [DEPTH];
  logic [CW-1:0]   r_count;
  logic [63:0]     r_seg;
  logic            w_ready;
  logic            w_accept;
  logic            w_blink;
  logic [7:0]      w_enc [8];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (s_in.in_valid) w_state_nxt = UPDATE;
      end
      UPDATE:  w_state_nxt = RENDER;
      RENDER:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept      = s_in.in_valid & w_ready;
  assign s_in.in_ready = w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd  <= CMD_PUT;
      r_char <= '0;
    end else if (w_accept) begin
      r_cmd  <= cmd_e'(s_in.in_cmd);
      r_char <= s_in.in_char;
    end
  end

  // Index 0 holds the newest character; a put shifts everything one slot older,
  // so the oldest entry falls off the end when the buffer is full.
  always_ff @(posedge clk) begin
    if (!rst && r_state == UPDATE) begin
      if (r_cmd == CMD_PUT) begin
        for (int unsigned i = DEPTH - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
        r_buf[0] <= r_char;
      end else if (r_cmd == CMD_BKSP) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) r_buf[i] <= r_buf[i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_state == UPDATE) begin
      case (r_cmd)
        CMD_PUT:  if (r_count != FULL) r_count <= r_count + CW'(1);
        CMD_BKSP: if (r_count != '0)   r_count <= r_count - CW'(1);
        CMD_CLR:  r_count <= '0;
        default:  r_count <= r_count;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg_char_enc u_enc (
      .i_code (r_buf[g]),
      .o_seg  (w_enc[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= '0;
    end else if (r_state == RENDER) begin
      for (int unsigned i = 0; i < 8; i++)
        r_seg[i*8 +: 8] <= (CW'(i) < r_count) ? w_enc[i] : SEG_BLANK;
    end
  end

`ifdef SEG_TEXT_WRITER_CURSOR_BLINK_EN
  logic [BLINK_DIV-1:0] r_blink;

  always_ff @(posedge clk) begin
    if (rst) r_blink <= '0;
    else     r_blink <= r_blink + BLINK_DIV'(1);
  end

  assign w_blink = r_blink[BLINK_DIV-1] & (r_count != FULL);
`else
  assign w_blink = 1'b0;
`endif

  // Rendered bytes always carry dp=0, so OR-ing the cursor into bit 0 is exact.
  assign seg_data   = r_seg | {63'd0, w_blink};
  assign char_count = r_count;

endmodule

// File: tb/tb_seg_text_writer.sv
// Directed self-checking bench for seg_text_writer (default DEPTH=16, no cursor blink).
module tb_seg_text_writer;
  import seg_pkg::*;

  logic        clk;
  logic        rst;
  logic [63:0] seg_data;
  logic [4:0]  char_count;
  int          n_chk;
  int          n_err;
  int          acc;

  seg_text_writer_if u_if ();

  seg_text_writer #(.DEPTH(16), .BLINK_DIV(24)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (u_if.slave),
    .seg_data   (seg_data),
    .char_count (char_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command and check the two-cycle ready gap; caller is #1 after an edge.
  task automatic do_cmd(input logic [1:0] cmd, input logic [5:0] ch);
    for (int k = 0; k < 20 && !u_if.in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    chk("ready_before", {63'd0, u_if.in_ready}, 64'd1);
    u_if.in_valid = 1'b1;
    u_if.in_cmd   = cmd;
    u_if.in_char  = ch;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.in_cmd   = 2'($urandom_range(0, 3));
    u_if.in_char  = 6'($urandom_range(0, 63));
    chk("ready_low1", {63'd0, u_if.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("ready_low2", {63'd0, u_if.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("ready_back", {63'd0, u_if.in_ready}, 64'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    u_if.in_valid = 1'b0;
    u_if.in_cmd   = 2'b00;
    u_if.in_char  = 6'd0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_seg", seg_data, 64'h0);
    chk("rst_count", {59'd0, char_count}, 64'd0);
    chk("rst_ready", {63'd0, u_if.in_ready}, 64'd1);

    do_cmd(CMD_PUT, 6'd1);
    chk("put1_seg", seg_data, 64'h0000_0000_0000_0060);
    chk("put1_count", {59'd0, char_count}, 64'd1);

    do_cmd(CMD_CLR, 6'd0);
    chk("clr1_seg", seg_data, 64'h0);
    for (int c = 0; c < 10; c++) do_cmd(CMD_PUT, 6'(c));
    chk("scroll_seg", seg_data, 64'hDAF2_66B6_BEE0_FEF6);
    chk("scroll_count", {59'd0, char_count}, 64'd10);

    for (int c = 10; c < 17; c++) do_cmd(CMD_PUT, 6'(c));
    chk("ovf_count", {59'd0, char_count}, 64'd16);
    chk("ovf_seg", seg_data, 64'hF6EE_3E9C_7A9E_8EBC);
    repeat (9) do_cmd(CMD_BKSP, 6'd0);
    chk("bksp_count", {59'd0, char_count}, 64'd7);
    chk("bksp_seg", seg_data, 64'h0060_DAF2_66B6_BEE0);

    do_cmd(CMD_CLR, 6'd0);
    chk("clr2_count", {59'd0, char_count}, 64'd0);
    do_cmd(CMD_BKSP, 6'd0);
    chk("bksp0_count", {59'd0, char_count}, 64'd0);
    chk("bksp0_seg", seg_data, 64'h0);

    do_cmd(CMD_PUT, CH_DASH);
    do_cmd(CMD_PUT, CH_UNDERSCORE);
    do_cmd(CMD_PUT, 6'd38);
    do_cmd(CMD_PUT, 6'd63);
    do_cmd(CMD_PUT, 6'd8);
    chk("sym_count", {59'd0, char_count}, 64'd5);
    chk("sym_seg", seg_data, 64'h0000_0002_1000_00FE);
    do_cmd(CMD_RSVD, 6'd9);
    chk("rsvd_count", {59'd0, char_count}, 64'd5);
    chk("rsvd_seg", seg_data, 64'h0000_0002_1000_00FE);
    do_cmd(CMD_CLR, 6'd0);
    chk("clr5_count", {59'd0, char_count}, 64'd0);
    chk("clr5_seg", seg_data, 64'h0);

    acc = 0;
    u_if.in_valid = 1'b1;
    u_if.in_cmd   = CMD_PUT;
    u_if.in_char  = 6'd3;
    repeat (6) begin
      if (u_if.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b0;
    chk("hold_accepts", 64'(acc), 64'd2);
    chk("hold_count", {59'd0, char_count}, 64'd2);
    chk("hold_seg", seg_data, 64'h0000_0000_0000_F2F2);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_stable", {59'd0, char_count}, 64'd2);

    u_if.in_valid = 1'b1;
    u_if.in_cmd   = CMD_PUT;
    u_if.in_char  = 6'd4;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_ready", {63'd0, u_if.in_ready}, 64'd1);
    chk("mid_rst_count", {59'd0, char_count}, 64'd0);
    chk("mid_rst_seg", seg_data, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_idle_seg", seg_data, 64'h0);
    do_cmd(CMD_PUT, 6'd7);
    chk("post_rst_seg", seg_data, 64'h0000_0000_0000_00E0);
    chk("post_rst_count", {59'd0, char_count}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_text_writer.md
Name: seg_text_writer

Overview:
- Producer for the multiplexed 8-digit display scanner: accepts decoded character codes over a valid/ready handshake and stores them in a DEPTH-entry character buffer.
- Renders the 8 newest characters into the 64-bit segment word the scanner consumes.
- Sits between the Morse symbol decoder and the display driver. The newest character always appears on the rightmost digit, and older text scrolls left.

Parameters:
- DEPTH, 16, character buffer entries; legal range 8..64.
- BLINK_DIV, 24, width of the free-running cursor blink counter. Only used with CURSOR_BLINK_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  command/character valid.
- in_ready  output  1  block can accept a command this cycle.
- in_cmd  input  2  00 put char, 01 backspace, 10 clear, 11 reserved.
- in_char  input  6  character code; only meaningful for put.
- seg_data  output  64  segment word.
  - [63:56] is the leftmost digit, [7:0] the rightmost.
  - Each byte is {a,b,c,d,e,f,g,dp}, bit7=a, active-high.
- char_count  output  $clog2(DEPTH+1)  number of characters currently buffered.

Behaviour:
- Reset (synchronous; wins over everything):
  - state=IDLE, buffer empty, char_count=0.
  - seg_data=64'h0, in_ready=1, blink counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_cmd/in_char and go to UPDATE.
  - UPDATE: in_ready=0. Apply the command to the buffer and count, then go to RENDER.
  - RENDER: in_ready=0. Register the new seg_data from the 8 newest buffer entries, then go to IDLE.
- Latency and back-pressure:
  - seg_data reflects a command accepted at edge N on edge N+2.
  - in_ready is low for exactly 2 cycles after each accept, so sustained throughput is 1 command per 3 cycles.
  - in_valid held high while in_ready is low is not consumed. in_char/in_cmd may change freely while in_ready is low.
- put:
  - count<DEPTH: append at the newest position, count+1.
  - count==DEPTH: discard the oldest entry, shift, append; count stays DEPTH.
- backspace:
  - count>0: remove the newest entry, count-1.
  - count==0: no-op, but it still passes through UPDATE/RENDER.
- clear: count=0, all display digits blank.
- reserved (11): accepted, no buffer change, still passes through UPDATE/RENDER.
- Rendering:
  - Digit i (0=rightmost) shows buffer entry newest-i if i<count, else 8'h00.
  - Entries older than the newest 8 are stored but not shown. Backspace brings them back into view.
- Character encoding:
  - 0..9 are digits; 10..35 are A..Z as 7-segment approximations; 36 is '-' (8'h02); 37 is '_' (8'h10).
  - 38..63 render as blank (8'h00) but still occupy a buffer slot.
- Digit patterns: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex).
- dp is always 0 in the rendered bytes unless the optional feature is enabled.

Optional Feature:
- Macro SEG_TEXT_WRITER_CURSOR_BLINK_EN.
- Defined:
  - A BLINK_DIV-bit free-running counter increments every cycle; it is cleared only by rst.
  - seg_data[0] (dp of the rightmost digit) equals the counter MSB whenever count<DEPTH, and 0 when the buffer is full.
  - seg_data[0] is updated every cycle, independent of FSM state. All other bits follow the normal rules.
- Undefined: no counter exists and seg_data[0] is always 0.

Decomposition:
- Shared package seg_pkg holds:
  - command encodings (CMD_PUT, CMD_BKSP, CMD_CLR, CMD_RSVD);
  - character code constants (CH_DASH=36, CH_UNDERSCORE=37);
  - SEG_BLANK=8'h00;
  - the state enum (IDLE, UPDATE, RENDER).
- One sub-module is natural: seg_char_enc, purely combinational, 6-bit code in to 8-bit segment byte out, instantiated per displayed digit or muxed.

Test Plan:
- Reset: hold rst 2 cycles -> seg_data=0, char_count=0, in_ready=1.
- Single put: put code 1 -> in_ready low for 2 cycles; seg_data=64'h0000_0000_0000_0060 on the second edge after accept; char_count=1.
- Window scroll: put codes 0..9 in order -> seg_data bytes left to right = DA F2 66 B6 BE E0 FE F6 (digits 2..9); char_count=10.
- Overflow and backspace: put 17 chars into DEPTH=16 -> char_count stays 16 and the oldest is dropped. Then 9 backspaces -> char_count=7 and the leftmost digit is blank.
- Edge commands: backspace at count=0 -> count stays 0 and seg_data=0. Clear from count=5 -> seg_data=0, count=0. Cmd 11 -> no change, in_ready low 2 cycles.
- Handshake and reset: hold in_valid high for 6 cycles -> exactly 2 accepts. Assert rst while in UPDATE -> next cycle state IDLE, buffer empty, seg_data=0. With the macro defined, seg_data[0] toggles every 2^(BLINK_DIV-1) cycles.
